clic_irq_front: RTL

Interrupt front-end sitting directly upstream of `n_clic`. Takes `VecLen` asynchronous external interrupt lines, synchronizes and glitch-filters them, and turns qualifying events into one-cycle `pend_set` strobes. Each strobe sets the pending bit (bit 0) of the matching `n_clic` vector entry. Per-line trigger mode and a sticky overrun register are exposed through the core's CSR access port.

---
 rtl/clic_irq_front.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/clic_irq_front.sv
// clic_irq_front: external interrupt front-end for n_clic.
// Each line is synchronized, glitch-filtered and edge/level qualified before
// it becomes a one-cycle pend_set strobe. Mode and overrun state are CSRs.

package clic_irq_front_pkg;
  typedef logic [31:0] word_t;
  typedef logic [11:0] csr_addr_t;
  typedef logic [4:0]  zimm_t;

  // Encodings follow the RISC-V funct3 field of the Zicsr instructions.
  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_t;
endpackage

module clic_irq_front
  import clic_irq_front_pkg::*;
#(
  parameter int        VecLen       = 8,
  parameter int        SyncStages   = 2,
  parameter int        FilterCycles = 4,
  parameter csr_addr_t IrqModeAddr  = 12'h7C0,
  parameter csr_addr_t IrqOvrAddr   = 12'h7C1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [VecLen-1:0] irq_in,
  input  logic [VecLen-1:0] pend_status,
  output logic [VecLen-1:0] pend_set,
  input  logic              csr_enable,
  input  csr_addr_t         csr_addr,
  input  zimm_t             rs1_zimm,
  input  word_t             rs1_data,
  input  csr_op_t           csr_op,
  output word_t             out
);

  localparam int CntW  = (FilterCycles > 1) ? $clog2(FilterCycles) : 1;
  localparam int ModeW = 2 * VecLen;
  localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

  typedef enum logic [1:0] {WR_NONE, WR_WRITE, WR_SET, WR_CLEAR} wr_kind_t;

  logic [SyncStages-1:0][VecLen-1:0] sync_q;
  logic [VecLen-1:0][CntW-1:0]       cnt_q;
  logic [VecLen-1:0]                 s, f_q, p_q;
  logic [VecLen-1:0]                 evt, edge_evt, ovr_hw;
  logic [ModeW-1:0]                  mode_q, mode_d;
  logic [VecLen-1:0]                 ovr_q, ovr_d;
  logic                              mode_sel, ovr_sel;
  word_t                             operand;
  wr_kind_t                          wr_kind;

  assign s = sync_q[SyncStages-1];

  // Synchronizer chain: stage 0 samples the raw asynchronous lines.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the chain is small flop storage, not a RAM, so clearing it on reset costs nothing.
      sync_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SyncStages; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Glitch filter plus one-cycle edge history of the filtered level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      f_q   <= '0;
      p_q   <= '0;
    end else begin
      p_q <= f_q;
      for (int i = 0; i < VecLen; i++) begin
        if (s[i] == f_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntLast) begin
          f_q[i]   <= s[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Mode-selected event per line; only edge modes can flag an overrun.
  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    evt      = '0;
    edge_evt = '0;
    for (int i = 0; i < VecLen; i++) begin
      case (mode_q[2*i +: 2])
        2'b01: begin
          evt[i]      = f_q[i] & ~p_q[i];
          edge_evt[i] = evt[i];
        end
        2'b10: begin
          evt[i]      = ~f_q[i] & p_q[i];
          edge_evt[i] = evt[i];
        end
        2'b11:   evt[i] = f_q[i] & ~pend_status[i];
        default: ;
      endcase
    end
  end

  assign ovr_hw = edge_evt & pend_status;

  // Decode the CSR operation into an operand and a write kind.
  always_comb begin
    operand = rs1_data;
    wr_kind = WR_NONE;
    case (csr_op)
      CSR_RW:  wr_kind = WR_WRITE;
      CSR_RS:  wr_kind = WR_SET;
      CSR_RC:  wr_kind = WR_CLEAR;
      CSR_RWI: begin operand = word_t'(rs1_zimm); wr_kind = WR_WRITE; end
      CSR_RSI: begin operand = word_t'(rs1_zimm); wr_kind = WR_SET;   end
      CSR_RCI: begin operand = word_t'(rs1_zimm); wr_kind = WR_CLEAR; end
      default: ;
    endcase
    // Set/clear with a zero operand is a pure read.
    if ((wr_kind == WR_SET || wr_kind == WR_CLEAR) && operand == '0) wr_kind = WR_NONE;
    if (!csr_enable) wr_kind = WR_NONE;
  end

  assign mode_sel = csr_enable && (csr_addr == IrqModeAddr);
  assign ovr_sel  = csr_enable && (csr_addr == IrqOvrAddr);

  // Read data shows the pre-write register value.
  assign out = mode_sel ? word_t'(mode_q) :
               ovr_sel  ? word_t'(ovr_q)  : '0;

  // Next values of the CSRs; a hardware overrun set beats a software clear.
  always_comb begin
    mode_d = mode_q;
    ovr_d  = ovr_q;
    if (mode_sel) begin
      case (wr_kind)
        WR_WRITE: mode_d = operand[ModeW-1:0];
        WR_SET:   mode_d = mode_q | operand[ModeW-1:0];
        WR_CLEAR: mode_d = mode_q & ~operand[ModeW-1:0];
        default:  ;
      endcase
    end
    if (ovr_sel) begin
      case (wr_kind)
        WR_WRITE: ovr_d = operand[VecLen-1:0];
        WR_SET:   ovr_d = ovr_q | operand[VecLen-1:0];
        WR_CLEAR: ovr_d = ovr_q & ~operand[VecLen-1:0];
        default:  ;
      endcase
    end
    ovr_d = ovr_d | ovr_hw;
  end

  // CSR registers and the registered pend_set strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q   <= '0;
      ovr_q    <= '0;
      pend_set <= '0;
    end else begin
      mode_q   <= mode_d;
      ovr_q    <= ovr_d;
      pend_set <= evt;
    end
  end

endmodule
